// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle CPU control path and datapath.
package multicycle_pkg;

    // Opcodes, inst[15:12]
    localparam logic [3:0] OpBne   = 4'd0;
    localparam logic [3:0] OpBeq   = 4'd1;
    localparam logic [3:0] OpBgz   = 4'd2;
    localparam logic [3:0] OpBlz   = 4'd3;
    localparam logic [3:0] OpAdi   = 4'd4;
    localparam logic [3:0] OpOri   = 4'd5;
    localparam logic [3:0] OpLhi   = 4'd6;
    localparam logic [3:0] OpLwd   = 4'd7;
    localparam logic [3:0] OpSwd   = 4'd8;
    localparam logic [3:0] OpJmp   = 4'd9;
    localparam logic [3:0] OpJal   = 4'd10;
    localparam logic [3:0] OpRtype = 4'd15;

    // R-type func codes, inst[5:0]; 0-7 are plain ALU ops
    localparam logic [5:0] FuncJpr = 6'd25;
    localparam logic [5:0] FuncJrl = 6'd26;
    localparam logic [5:0] FuncWwd = 6'd28;
    localparam logic [5:0] FuncHlt = 6'd29;

    typedef enum logic [3:0] {
        StIf   = 4'd0,
        StId   = 4'd1,
        StExR  = 4'd2,
        StExI  = 4'd3,
        StWbR  = 4'd4,
        StWbI  = 4'd5,
        StMa   = 4'd6,
        StMr   = 4'd7,
        StWbM  = 4'd8,
        StMw   = 4'd9,
        StBr   = 4'd10,
        StExJ  = 4'd11,
        StWwd  = 4'd12,
        StHalt = 4'd13
    } state_e;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOrr = 3'b011,
        AluNot = 3'b100,
        AluTcp = 3'b101,
        AluShl = 3'b110,
        AluShr = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SrcBReg  = 2'b00,
        SrcBOne  = 2'b01,
        SrcBImm  = 2'b10,
        SrcBZero = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PcSrcAlu    = 2'b00,
        PcSrcAluOut = 2'b01,
        PcSrcJump   = 2'b10
    } pc_source_e;

    typedef enum logic [1:0] {
        MemToRegAluOut = 2'b00,
        MemToRegMdr    = 2'b01,
        MemToRegPc     = 2'b10,
        MemToRegLhi    = 2'b11
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        RegDstRt   = 2'b00,   // inst[9:8]
        RegDstRd   = 2'b01,   // inst[7:6]
        RegDstLink = 2'b10    // register 2
    } reg_dst_e;

    typedef enum logic [3:0] {
        ClsNop    = 4'd0,
        ClsRAlu   = 4'd1,
        ClsWwd    = 4'd2,
        ClsJpr    = 4'd3,
        ClsJrl    = 4'd4,
        ClsHlt    = 4'd5,
        ClsAdi    = 4'd6,
        ClsOri    = 4'd7,
        ClsLhi    = 4'd8,
        ClsLwd    = 4'd9,
        ClsSwd    = 4'd10,
        ClsBrCmp  = 4'd11,   // BNE/BEQ: compare A against B
        ClsBrZero = 4'd12,   // BGZ/BLZ: test A against zero
        ClsJmp    = 4'd13,
        ClsJal    = 4'd14
    } inst_class_e;

endpackage

// File: rtl/inst_class_decode.sv
// Combinational instruction classifier: maps the IR to a class and the ALU op it needs.
module inst_class_decode
    import multicycle_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] inst_i,
    output inst_class_e          inst_class_o,
    output alu_op_e              alu_op_o
);

    logic [3:0] opcode;
    logic [5:0] func;
    logic       unused_inst;

    assign opcode      = inst_i[WORD_SIZE-1 -: 4];
    assign func        = inst_i[5:0];
    assign unused_inst = ^inst_i[WORD_SIZE-5:6];

    // Classify opcode/func; anything undefined decodes as a NOP
    always_comb begin
        inst_class_o = ClsNop;
        alu_op_o     = AluAdd;
        case (opcode)
            OpBne, OpBeq: begin
                inst_class_o = ClsBrCmp;
                alu_op_o     = AluSub;
            end
            OpBgz, OpBlz: inst_class_o = ClsBrZero;
            OpAdi:        inst_class_o = ClsAdi;
            OpOri: begin
                inst_class_o = ClsOri;
                alu_op_o     = AluOrr;
            end
            OpLhi:        inst_class_o = ClsLhi;
            OpLwd:        inst_class_o = ClsLwd;
            OpSwd:        inst_class_o = ClsSwd;
            OpJmp:        inst_class_o = ClsJmp;
            OpJal:        inst_class_o = ClsJal;
            OpRtype: begin
                if (func[5:3] == 3'b000) begin
                    inst_class_o = ClsRAlu;
                    alu_op_o     = alu_op_e'(func[2:0]);
                end else begin
                    case (func)
                        FuncJpr: inst_class_o = ClsJpr;
                        FuncJrl: inst_class_o = ClsJrl;
                        FuncWwd: inst_class_o = ClsWwd;
                        FuncHlt: inst_class_o = ClsHlt;
                        default: inst_class_o = ClsNop;
                    endcase
                end
            end
            default: inst_class_o = ClsNop;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences the datapath one microstep per clock.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] inst,
    input  logic                 mem_ready,
    output logic                 read_m1,
    output logic                 read_m2,
    output logic                 write_m2,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 reg_write,
    output logic                 write_port,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 imm_zero_ext,
    output logic [2:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [1:0]           mem_to_reg,
    output logic [1:0]           reg_dst,
    output logic                 is_halted,
    output logic [WORD_SIZE-1:0] num_inst
);

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;
    inst_class_e          inst_class;
    alu_op_e              dec_alu_op;
    logic                 retire;

    inst_class_decode #(
        .WORD_SIZE (WORD_SIZE)
    ) u_decode (
        .inst_i       (inst),
        .inst_class_o (inst_class),
        .alu_op_o     (dec_alu_op)
    );

    // Next-state and retire-count logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIf: if (mem_ready) state_d = StId;
            StId: begin
                case (inst_class)
                    ClsRAlu, ClsWwd:    state_d = StExR;
                    ClsAdi, ClsOri:     state_d = StExI;
                    ClsLwd, ClsSwd:     state_d = StMa;
                    ClsBrCmp, ClsBrZero: state_d = StBr;
                    ClsJpr, ClsJrl:     state_d = StExJ;
                    ClsHlt:             state_d = StHalt;
                    default:            state_d = StIf;   // JMP, JAL, LHI, NOP
                endcase
            end
            StExR:  state_d = (inst_class == ClsWwd) ? StWwd : StWbR;
            StExI:  state_d = StWbI;
            StMa:   state_d = (inst_class == ClsSwd) ? StMw : StMr;
            StMr:   if (mem_ready) state_d = StWbM;
            StMw:   if (mem_ready) state_d = StIf;
            StWbR, StWbI, StWbM, StBr, StExJ, StWwd: state_d = StIf;
            StHalt: state_d = StHalt;
            default: state_d = StIf;
        endcase

        retire = ((state_d == StIf) && (state_q != StIf)) ||
                 ((state_d == StHalt) && (state_q != StHalt));
        num_inst_d = retire ? num_inst_q + {{(WORD_SIZE-1){1'b0}}, 1'b1} : num_inst_q;
    end

    // State and counter registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIf;
            num_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            num_inst_q <= num_inst_d;
        end
    end

    // Datapath controls decoded from the current state; all forced low during reset
    always_comb begin
        read_m1       = 1'b0;
        read_m2       = 1'b0;
        write_m2      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        write_port    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SrcBReg;
        imm_zero_ext  = 1'b0;
        alu_op        = AluAdd;
        pc_source     = PcSrcAlu;
        mem_to_reg    = MemToRegAluOut;
        reg_dst       = RegDstRt;
        is_halted     = 1'b0;

        unique case (state_q)
            StIf: begin
                read_m1   = 1'b1;
                alu_src_b = SrcBOne;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StId: begin
                // ALUOut <- PC+1+sext(imm) for a possible branch
                alu_src_b = SrcBImm;
                case (inst_class)
                    ClsJmp: begin
                        pc_write  = 1'b1;
                        pc_source = PcSrcJump;
                    end
                    ClsJal: begin
                        pc_write   = 1'b1;
                        pc_source  = PcSrcJump;
                        reg_write  = 1'b1;
                        reg_dst    = RegDstLink;
                        mem_to_reg = MemToRegPc;
                    end
                    ClsLhi: begin
                        reg_write  = 1'b1;
                        reg_dst    = RegDstRt;
                        mem_to_reg = MemToRegLhi;
                    end
                    default: ;
                endcase
            end
            StExR: begin
                alu_src_a = 1'b1;
                alu_src_b = (inst_class == ClsWwd) ? SrcBZero : SrcBReg;
                alu_op    = dec_alu_op;
            end
            StWbR: begin
                reg_write = 1'b1;
                reg_dst   = RegDstRd;
            end
            StExI: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SrcBImm;
                alu_op       = dec_alu_op;
                imm_zero_ext = (inst_class == ClsOri);
            end
            StWbI: reg_write = 1'b1;
            StMa: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StMr: read_m2 = 1'b1;
            StWbM: begin
                reg_write  = 1'b1;
                mem_to_reg = MemToRegMdr;
            end
            StMw: write_m2 = 1'b1;
            StBr: begin
                pc_write_cond = 1'b1;
                pc_source     = PcSrcAluOut;
                alu_src_a     = 1'b1;
                alu_src_b     = (inst_class == ClsBrCmp) ? SrcBReg : SrcBZero;
                alu_op        = dec_alu_op;
            end
            StExJ: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBZero;
                pc_write  = 1'b1;
                if (inst_class == ClsJrl) begin
                    reg_write  = 1'b1;
                    reg_dst    = RegDstLink;
                    mem_to_reg = MemToRegPc;
                end
            end
            StWwd:  write_port = 1'b1;
            StHalt: is_halted  = 1'b1;
            default: ;
        endcase

        if (!reset_n) begin
            read_m1       = 1'b0;
            read_m2       = 1'b0;
            write_m2      = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            write_port    = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            imm_zero_ext  = 1'b0;
            alu_op        = 3'b000;
            pc_source     = 2'b00;
            mem_to_reg    = 2'b00;
            reg_dst       = 2'b00;
            is_halted     = 1'b0;
        end
    end

    assign num_inst = reset_n ? num_inst_q : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] inst;
    logic        mem_ready;
    logic        read_m1, read_m2, write_m2, ir_write, pc_write, pc_write_cond;
    logic        reg_write, write_port, alu_src_a, imm_zero_ext, is_halted;
    logic [1:0]  alu_src_b, pc_source, mem_to_reg, reg_dst;
    logic [2:0]  alu_op;
    logic [15:0] num_inst;

    always #5 clk = ~clk;

    multicycle_control #(
        .WORD_SIZE (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .inst          (inst),
        .mem_ready     (mem_ready),
        .read_m1       (read_m1),
        .read_m2       (read_m2),
        .write_m2      (write_m2),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .reg_write     (reg_write),
        .write_port    (write_port),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_zero_ext  (imm_zero_ext),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .is_halted     (is_halted),
        .num_inst      (num_inst)
    );

    // Field order of the packed control word
    logic [21:0] ctl;
    assign ctl = {read_m1, read_m2, write_m2, ir_write, pc_write, pc_write_cond, reg_write,
                  write_port, alu_src_a, alu_src_b, imm_zero_ext, alu_op, pc_source,
                  mem_to_reg, reg_dst, is_halted};

    //                          rm1  rm2  wm2  irw  pcw  pcc  rgw  wpt  srcA srcB  zext op     pcs   m2r   dst   hlt
    localparam logic [21:0] SigZero    = 22'd0;
    localparam logic [21:0] SigIfReady = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,3'b000,2'b00,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigIfWait  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,3'b000,2'b00,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigIdGen   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,3'b000,2'b00,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigIdJmp   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,3'b000,2'b10,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigIdJal   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b10,1'b0,3'b000,2'b10,2'b10,2'b10,1'b0};
    localparam logic [21:0] SigExRAdd  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,3'b000,2'b00,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigWbR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,2'b00,2'b01,1'b0};
    localparam logic [21:0] SigExIOri  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,3'b011,2'b00,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigWbI     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigMa      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,3'b000,2'b00,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigMr      = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigWbM     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,2'b01,2'b00,1'b0};
    localparam logic [21:0] SigBrBeq   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,1'b0,3'b001,2'b01,2'b00,2'b00,1'b0};
    localparam logic [21:0] SigHalt    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,3'b000,2'b00,2'b00,2'b00,1'b1};

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_num = 16'd0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        inst      = 16'hF1C0;
        #1;
        total++;
        if (ctl !== SigZero) begin
            bad++; $display("FAIL reset_pre_edge ctl: got %b want %b", ctl, SigZero);
        end
        cyc();
        total++;
        if (ctl !== SigZero) begin
            bad++; $display("FAIL reset_held ctl: got %b want %b", ctl, SigZero);
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (ctl !== SigIfReady) begin
            bad++; $display("FAIL reset_if ctl: got %b want %b", ctl, SigIfReady);
        end
        total++;
        if (num_inst !== 16'd0) begin
            bad++; $display("FAIL reset_num_inst: got %0d want 0", num_inst);
        end
    endtask

    task automatic test_add();
        inst = 16'hF1C0;
        #1;
        cyc();
        total++;
        if (ctl !== SigIdGen) begin
            bad++; $display("FAIL add_id ctl: got %b want %b", ctl, SigIdGen);
        end
        cyc();
        total++;
        if (ctl !== SigExRAdd) begin
            bad++; $display("FAIL add_exr ctl: got %b want %b", ctl, SigExRAdd);
        end
        cyc();
        total++;
        if (ctl !== SigWbR) begin
            bad++; $display("FAIL add_wbr ctl: got %b want %b", ctl, SigWbR);
        end
        cyc();
        exp_num = exp_num + 16'd1;
        total++;
        if (ctl !== SigIfReady || num_inst !== exp_num) begin
            bad++; $display("FAIL add_done: ctl %b num %0d want %b num %0d", ctl, num_inst, SigIfReady, exp_num);
        end
    endtask

    task automatic test_lwd_wait();
        inst = 16'h7401;
        #1;
        cyc();
        total++;
        if (ctl !== SigIdGen) begin
            bad++; $display("FAIL lwd_id ctl: got %b want %b", ctl, SigIdGen);
        end
        cyc();
        total++;
        if (ctl !== SigMa) begin
            bad++; $display("FAIL lwd_ma ctl: got %b want %b", ctl, SigMa);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) mem_ready = 1'b1;
            #1;
            total++;
            if (ctl !== SigMr) begin
                bad++; $display("FAIL lwd_mr%0d ctl: got %b want %b", i, ctl, SigMr);
            end
        end
        cyc();
        total++;
        if (ctl !== SigWbM) begin
            bad++; $display("FAIL lwd_wbm ctl: got %b want %b", ctl, SigWbM);
        end
        cyc();
        exp_num = exp_num + 16'd1;
        total++;
        if (ctl !== SigIfReady || num_inst !== exp_num) begin
            bad++; $display("FAIL lwd_done: ctl %b num %0d want %b num %0d", ctl, num_inst, SigIfReady, exp_num);
        end
    endtask

    task automatic test_beq();
        inst = 16'h1405;
        #1;
        cyc();
        total++;
        if (ctl !== SigIdGen) begin
            bad++; $display("FAIL beq_id ctl: got %b want %b", ctl, SigIdGen);
        end
        cyc();
        total++;
        if (ctl !== SigBrBeq) begin
            bad++; $display("FAIL beq_br ctl: got %b want %b", ctl, SigBrBeq);
        end
        cyc();
        exp_num = exp_num + 16'd1;
        total++;
        if (ctl !== SigIfReady || num_inst !== exp_num) begin
            bad++; $display("FAIL beq_done: ctl %b num %0d want %b num %0d", ctl, num_inst, SigIfReady, exp_num);
        end
    endtask

    task automatic test_jal();
        inst = 16'hA123;
        #1;
        cyc();
        total++;
        if (ctl !== SigIdJal) begin
            bad++; $display("FAIL jal_id ctl: got %b want %b", ctl, SigIdJal);
        end
        cyc();
        exp_num = exp_num + 16'd1;
        total++;
        if (ctl !== SigIfReady || num_inst !== exp_num) begin
            bad++; $display("FAIL jal_done: ctl %b num %0d want %b num %0d", ctl, num_inst, SigIfReady, exp_num);
        end
    endtask

    task automatic test_ori();
        inst = 16'h5203;
        #1;
        cyc();
        cyc();
        total++;
        if (ctl !== SigExIOri) begin
            bad++; $display("FAIL ori_exi ctl: got %b want %b", ctl, SigExIOri);
        end
        cyc();
        total++;
        if (ctl !== SigWbI) begin
            bad++; $display("FAIL ori_wbi ctl: got %b want %b", ctl, SigWbI);
        end
        cyc();
        exp_num = exp_num + 16'd1;
        total++;
        if (ctl !== SigIfReady || num_inst !== exp_num) begin
            bad++; $display("FAIL ori_done: ctl %b num %0d want %b num %0d", ctl, num_inst, SigIfReady, exp_num);
        end
    endtask

    task automatic test_if_stall();
        inst      = 16'h9000;
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ctl !== SigIfWait) begin
                bad++; $display("FAIL stall_wait%0d ctl: got %b want %b", i, ctl, SigIfWait);
            end
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (ctl !== SigIfReady) begin
            bad++; $display("FAIL stall_release ctl: got %b want %b", ctl, SigIfReady);
        end
        cyc();
        total++;
        if (ctl !== SigIdJmp) begin
            bad++; $display("FAIL stall_jmp_id ctl: got %b want %b", ctl, SigIdJmp);
        end
        cyc();
        exp_num = exp_num + 16'd1;
        total++;
        if (ctl !== SigIfReady || num_inst !== exp_num) begin
            bad++; $display("FAIL stall_done: ctl %b num %0d want %b num %0d", ctl, num_inst, SigIfReady, exp_num);
        end
    endtask

    task automatic test_halt();
        inst = 16'hF01D;
        #1;
        cyc();
        cyc();
        exp_num = exp_num + 16'd1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (ctl !== SigHalt || num_inst !== exp_num) begin
                bad++; $display("FAIL halt%0d: ctl %b num %0d want %b num %0d", i, ctl, num_inst, SigHalt, exp_num);
            end
            cyc();
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (ctl !== SigZero) begin
            bad++; $display("FAIL halt_reset_force ctl: got %b want %b", ctl, SigZero);
        end
        cyc();
        reset_n = 1'b1;
        #1;
        total++;
        if (ctl !== SigIfReady || num_inst !== 16'd0) begin
            bad++; $display("FAIL halt_after_reset: ctl %b num %0d want %b num 0", ctl, num_inst, SigIfReady);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lwd_wait();
        test_beq();
        test_jal();
        test_ori();
        test_if_stall();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the 16-bit single-memory-port-pair CPU. It sits directly upstream of the datapath and sequences it one microstep per clock. It decodes the latched instruction, waits on memory-ready handshakes, and drives every datapath mux select and write enable. It also tracks halt and the retired-instruction count.

## Interface
Parameters:
- WORD_SIZE, 16, instruction and counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low
- inst  in  16  instruction register contents from the datapath
- mem_ready  in  1  memory access of the current cycle completes this cycle
- read_m1, read_m2, write_m2  out  1  instruction read, data read, data write requests
- ir_write, pc_write, pc_write_cond, reg_write, write_port  out  1  datapath enables
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = +1, 10 = extended imm, 11 = zero
- imm_zero_ext  out  1  1 = zero-extend imm8, 0 = sign-extend imm8
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 NOT, 101 TCP, 110 SHL, 111 SHR
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[15:12], inst[11:0]}
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC, 11 = {imm8, 8'h00}
- reg_dst  out  2  00 = inst[9:8], 01 = inst[7:6], 10 = register 2
- is_halted  out  1  HLT retired
- num_inst  out  16  retired-instruction count

## Operation
- Opcode is inst[15:12].
  - Branches: 0 BNE, 1 BEQ, 2 BGZ, 3 BLZ.
  - Immediate and memory: 4 ADI, 5 ORI, 6 LHI, 7 LWD, 8 SWD.
  - Jumps: 9 JMP, 10 JAL.
  - Opcode 15 is R-type with func inst[5:0]: 0–7 map to ALU ops 000–111, 25 JPR, 26 JRL, 28 WWD, 29 HLT.
- States: IF, ID, EX_R, EX_I, WB_R, WB_I, MA, MR, WB_M, MW, BR, EX_J, WWD, HALT. The encoding is set in the package.
- IF: assert read_m1, alu_src_a=0, alu_src_b=01, ADD, pc_source=00. When mem_ready, assert ir_write and pc_write, then go to ID. Otherwise stay in IF.
- ID: alu_src_a=0, alu_src_b=10, sign-extend, ADD. This latches the branch target PC+1+imm into ALUOut.
  - JMP: pc_write, pc_source=10, then IF.
  - JAL: same as JMP, plus reg_write, reg_dst=10, mem_to_reg=10 (links the incremented PC).
  - LHI: reg_write, reg_dst=00, mem_to_reg=11, then IF.
  - Other decodes go to their own states. An undefined opcode or func goes to IF and is treated as a NOP.
- EX_R: alu_src_a=1, alu_src_b=00, alu_op from func, then WB_R.
- WB_R: reg_write, reg_dst=01, mem_to_reg=00.
- EX_I: alu_src_a=1, alu_src_b=10, ADD for ADI, ORR with imm_zero_ext=1 for ORI, then WB_I.
- WB_I: reg_write, reg_dst=00, mem_to_reg=00.
- LWD / SWD: MA computes A+sext(imm), then MR (LWD) or MW (SWD).
  - MR holds read_m2 until mem_ready, then goes to WB_M.
  - WB_M: reg_write, reg_dst=00, mem_to_reg=01.
  - MW holds write_m2 until mem_ready, then goes to IF.
- BR: pc_write_cond, pc_source=01, alu_src_a=1.
  - BNE/BEQ: alu_src_b=00, SUB.
  - BGZ/BLZ: alu_src_b=11, ADD.
  - The datapath evaluates the condition.
- EX_J (JPR/JRL): alu_src_a=1, alu_src_b=11, ADD, pc_source=00, pc_write. JRL additionally asserts the JAL link writes.
- WWD: EX_R with alu_src_b=11 and ADD, then the WWD state asserts write_port.
- HLT: ID goes to HALT. HALT asserts is_halted and stays there until reset; no memory requests are issued.
- num_inst increments by 1 on every transition into IF from a non-IF state, and on entry to HALT. It wraps at 16'hFFFF.

## Timing
- Outputs are decoded from the current state, with the inst fields as the only extra input.
- On the reset_n=0 edge: state←IF, num_inst←0.
- While reset_n=0, every output is forced to 0, including is_halted.
- Reset mid-instruction aborts it without counting it.
- Cycle counts with zero wait states:
  - JMP/JAL/LHI/undefined: 2
  - branch, JPR/JRL, HLT (to HALT): 3
  - R-ALU, ADI/ORI, SWD, WWD: 4
  - LWD: 5
- Each cycle mem_ready is low in IF, MR or MW adds one cycle. No enables other than the request are asserted while waiting.
- mem_ready is ignored in all other states.

## Structure
- Package multicycle_pkg holds:
  - opcode and func constants
  - state encoding
  - the ALU op code
  - the alu_src_b, pc_source, mem_to_reg and reg_dst encodings
- The datapath imports the same package.
- One sub-module, inst_class_decode: combinational; maps inst to an instruction class and alu_op; used by the next-state and output logic.

## Test plan
- ADD: after reset, inst=16'hF1C0 (ADD $3,$0,$1), mem_ready=1 always. Expect states IF, ID, EX_R, WB_R. In WB_R: reg_write=1, reg_dst=01. Then num_inst=1.
- LWD with wait: inst=16'h7401, mem_ready low for 2 cycles in MR. Expect read_m2 held for 3 cycles, then WB_M with mem_to_reg=01. Total 7 cycles.
- BEQ: inst=16'h1405. In BR: pc_write_cond=1, pc_source=01, alu_op=SUB. Next state IF after 3 cycles.
- JAL: inst=16'hA123. In ID: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. Back to IF after 2 cycles.
- HLT: inst=16'hF01D. Expect is_halted=1 and read_m1=0 for 10 cycles; num_inst incremented once. A reset_n pulse returns the FSM to IF with num_inst=0.
- IF stall: mem_ready=0 for 5 cycles. read_m1 stays 1 while pc_write and ir_write stay 0, then both pulse for exactly one cycle.
